// File: rtl/axi_st_d128_half_unpack.sv
// Re-serialises a two-half wide AXI-ST beat into a full-rate narrow stream.
// Enabled halves are emitted lower first, then upper; beats with no enabled half are counted and dropped.
module axi_st_d128_half_unpack #(
  parameter int HALF_DW = 128,
  parameter int HALF_KW = 16,
  parameter int CNT_W   = 16
) (
  input  logic                 clk_wr,
  input  logic                 rst_wr,
  input  logic [2*HALF_DW-1:0] in_tdata,
  input  logic [2*HALF_KW-1:0] in_tkeep,
  input  logic [1:0]           in_tuser,
  input  logic [1:0]           in_enable,
  input  logic                 in_tvalid,
  output logic                 in_tready,
  output logic [HALF_DW-1:0]   out_tdata,
  output logic [HALF_KW-1:0]   out_tkeep,
  output logic                 out_tuser,
  output logic                 out_tvalid,
  input  logic                 out_tready,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic [31:0]          beat_cnt
);

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  state_t               state_p0, state_d;
  logic [2*HALF_DW-1:0] hold_tdata_p0;
  logic [2*HALF_KW-1:0] hold_tkeep_p0;
  logic [1:0]           hold_tuser_p0;
  logic [1:0]           hold_en_p0;
  logic [CNT_W-1:0]     drop_cnt_p0;
  logic [31:0]          beat_cnt_p0;
  logic                 last_half, in_hs, out_hs;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // The held beat may be replaced only once its final pending half leaves
  assign last_half  = (state_p0 == HI) || ((state_p0 == LO) && !hold_en_p0[1]);
  assign out_tvalid = (state_p0 != IDLE);
  assign in_tready  = !rst_wr && ((state_p0 == IDLE) || (last_half && out_tvalid && out_tready));
  assign in_hs      = in_tvalid && in_tready;
  assign out_hs     = out_tvalid && out_tready;

  always_comb begin
    state_d = state_p0;
    if (in_hs) begin
      case (in_enable)
        2'b00:   state_d = IDLE;
        2'b10:   state_d = HI;
        default: state_d = LO;
      endcase
    end else if (out_hs) begin
      state_d = ((state_p0 == LO) && hold_en_p0[1]) ? HI : IDLE;
    end
  end

  always_comb begin
    out_tdata = '0;
    out_tkeep = '0;
    out_tuser = 1'b0;
    case (state_p0)
      LO: begin
        out_tdata = hold_tdata_p0[HALF_DW-1:0];
        out_tkeep = hold_tkeep_p0[HALF_KW-1:0];
        out_tuser = hold_tuser_p0[0];
      end
      HI: begin
        out_tdata = hold_tdata_p0[2*HALF_DW-1:HALF_DW];
        out_tkeep = hold_tkeep_p0[2*HALF_KW-1:HALF_KW];
        out_tuser = hold_tuser_p0[1];
      end
      default: ;
    endcase
  end

  // Stage p0: holding register, state and counters
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      state_p0      <= IDLE;
      hold_tdata_p0 <= '0;
      hold_tkeep_p0 <= '0;
      hold_tuser_p0 <= '0;
      hold_en_p0    <= '0;
      drop_cnt_p0   <= '0;
      beat_cnt_p0   <= '0;
    end else begin
      state_p0 <= state_d;
      if (in_hs) begin
        hold_tdata_p0 <= in_tdata;
        hold_tkeep_p0 <= in_tkeep;
        hold_tuser_p0 <= in_tuser;
        hold_en_p0    <= in_enable;
        if (in_enable == 2'b00)
          drop_cnt_p0 <= sat_inc(drop_cnt_p0);
      end
      if (out_hs)
        beat_cnt_p0 <= beat_cnt_p0 + 32'd1;
    end
  end

  assign drop_cnt = drop_cnt_p0;
  assign beat_cnt = beat_cnt_p0;

endmodule

// File: doc/axi_st_d128_half_unpack.md
# axi_st_d128_half_unpack

Downstream stage of the AXI-ST half-rate slave top. It consumes the 256-bit, two-half beat (tdata/tkeep/tuser plus per-half `enable`) delivered by the receive side. It then re-serialises the enabled halves into a full-rate 128-bit AXI-ST stream for the user fabric. It holds one wide beat and presents its enabled halves in order: lower half first, then upper. Standard valid/ready backpressure applies on both sides.

## Interface
Parameters:
- `HALF_DW`, 128: data bits per half; input width is 2*HALF_DW.
- `HALF_KW`, 16: tkeep bits per half (HALF_DW/8).
- `CNT_W`, 16: width of the saturating drop counter.

Ports:
- `clk_wr`  in  1  clock; everything synchronous to its rising edge.
- `rst_wr`  in  1  synchronous, active-high reset.
- `in_tdata`  in  2*HALF_DW  wide beat; half 0 = [HALF_DW-1:0].
- `in_tkeep`  in  2*HALF_KW  byte keeps; half 0 = [HALF_KW-1:0].
- `in_tuser`  in  2  tuser[h] belongs to half h.
- `in_enable`  in  2  enable[h]=1 means half h carries data.
- `in_tvalid`  in  1  wide beat valid.
- `in_tready`  out  1  wide beat accepted when in_tvalid & in_tready.
- `out_tdata`  out  HALF_DW  narrow beat data.
- `out_tkeep`  out  HALF_KW  narrow beat keeps.
- `out_tuser`  out  1  narrow beat user bit.
- `out_tvalid`  out  1  narrow beat valid.
- `out_tready`  in  1  downstream ready.
- `drop_cnt`  out  CNT_W  count of accepted beats with in_enable==2'b00; saturates at all-ones.
- `beat_cnt`  out  32  count of narrow beats transferred (out_tvalid & out_tready); wraps.

## Operation
- Holding register captures in_tdata/tkeep/tuser/enable on an input handshake.
- States:
  - IDLE: nothing held.
  - LO: lower half pending; upper may also be pending.
  - HI: only upper half pending.
- IDLE transitions on an input handshake, by enable:
  - 2'b01 and 2'b11 go to LO.
  - 2'b10 goes to HI.
  - 2'b00 stays in IDLE, increments drop_cnt, and produces no output.
- LO transitions on an output handshake:
  - If upper is enabled, go to HI.
  - Otherwise go to IDLE, or reload from a simultaneous input handshake.
- HI transitions on an output handshake: go to IDLE, or reload from a simultaneous input handshake.
- Output fields:
  - out_tvalid = (state != IDLE).
  - In LO, out_tdata/out_tkeep/out_tuser come from half 0 fields; in HI, from half 1 fields.
- in_tready = !rst_wr & (state==IDLE | (last pending half & out_tvalid & out_tready)). "Last pending half" means state==HI, or state==LO with held enable[1]==0. This is a combinational path from out_tready.
- Simultaneous drain of the last half and input acceptance: the new beat is loaded and the next state follows the IDLE rules. An enable==2'b00 beat accepted in this way moves the state to IDLE and increments drop_cnt.
- AXI rule: while out_tvalid & !out_tready, all out_* fields stay stable. Once out_tvalid is asserted, it stays asserted until the handshake completes.
- Counter behaviour:
  - drop_cnt saturates and does not wrap.
  - beat_cnt increments by 1 per output handshake and wraps from 0xFFFFFFFF to 0.
- Reset mid-operation: a held beat is discarded (not emitted) and the counters clear. in_tready is 0 during every cycle rst_wr is high.

## Timing
- Reset values:
  - state IDLE; holding register 0.
  - out_tvalid 0; out_tdata/out_tkeep/out_tuser 0.
  - drop_cnt 0; beat_cnt 0.
  - in_tready 0 while rst_wr=1, and 1 on the first cycle after release.
- Latency: input handshake at edge N gives out_tvalid=1 with the first half during cycle N+1.
- Throughput with out_tready held at 1:
  - enable 2'b11 beats give one narrow beat per cycle, with in_tready high every second cycle.
  - enable 2'b01 or 2'b10 beats stream at one wide beat per cycle.
- No bubbles are inserted between consecutive held beats when the input is valid at the drain cycle.

## Test plan
- Reset then single beat: in_tdata lower=A, upper=B, enable=2'b11, tuser=2'b10, out_tready=1.
  - Required: out cycle N+1 = A with tuser 0; cycle N+2 = B with tuser 1.
  - Required: in_tready low in cycle N+1 and high in cycle N+2; beat_cnt=2.
- Enable patterns 2'b01 then 2'b10 back-to-back: exactly one narrow beat each (lower of the first beat, upper of the second), on consecutive cycles with no bubble.
- enable=2'b00 beat sent three times: no out_tvalid, drop_cnt=3. Preloading drop_cnt to 0xFFFF and sending another 2'b00 beat holds 0xFFFF.
- Backpressure: out_tready=0 for 5 cycles while holding an enable=2'b11 beat.
  - Required: out_tdata stays equal to the lower half and in_tready stays 0.
  - On release, required: lower then upper, one cycle apart.
- Random stream of 1000 beats with random enable/out_tready: scoreboard checks order and content of enabled halves. Required: beat_cnt = number of enabled halves, drop_cnt = number of 2'b00 beats.
- Assert rst_wr for 1 cycle while in HI: out_tvalid=0 the next cycle, the pending half is never emitted, and both counters read 0.
